// File: rtl/ram1p_wbuf_pkg.sv
// Shared defaults for the write-buffer front end of the single-port byte-enable SRAM.
package ram1p_wbuf_pkg;

  localparam int DEPTH_DEF    = 64;
  localparam int WIDTH_DEF    = 64;
  localparam int NENTRIES_DEF = 4;
  localparam int STARVE_DEF   = 8;

  // Number of byte lanes for a given word width; the top lane may be partial.
  function automatic int lanes_of(input int w);
    return (w - 1) / 8 + 1;
  endfunction

endpackage

// File: rtl/ram1p_wbuf_chk.sv
// Protocol checker: a request accept and a buffer drain never share a cycle.
module ram1p_wbuf_chk (
  input logic clk,
  input logic resetn,
  input logic accept_i,
  input logic drain_i
);

  a_no_accept_and_drain: assert property (@(posedge clk) disable iff (!resetn)
    !(accept_i && drain_i));

endmodule

// File: rtl/ram1p_wbuf_wbufentry.sv
// One write-buffer entry: valid/addr/data/mask, address compare and byte merge.
module ram1p_wbuf_wbufentry
  import ram1p_wbuf_pkg::*;
#(
  parameter int AW    = 6,
  parameter int WIDTH = 64,
  parameter int NB    = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             alloc_i,
  input  logic             merge_i,
  input  logic             pop_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [NB-1:0]    wbe_i,
  output logic             match_o,
  output logic [AW-1:0]    addr_o,
  output logic [WIDTH-1:0] data_o,
  output logic [NB-1:0]    mask_o
);

  typedef struct packed {
    logic             valid;
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] data;
    logic [NB-1:0]    mask;
  } entry_t;

  entry_t           entry_q;
  entry_t           entry_d;
  logic [WIDTH-1:0] wmask_s;

  // Expand a lane enable vector into a per-bit mask.
  function automatic logic [WIDTH-1:0] lane_bits(input logic [NB-1:0] be);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int b = 0; b < WIDTH; b++) begin
      r[b] = be[b / 8];
    end
    return r;
  endfunction

  // Next entry state: pop clears, allocate loads, merge overlays enabled lanes.
  always_comb begin
    entry_d = entry_q;
    wmask_s = lane_bits(wbe_i);
    if (pop_i) begin
      entry_d.valid = 1'b0;
      entry_d.mask  = '0;
    end else if (alloc_i) begin
      entry_d.valid = 1'b1;
      entry_d.addr  = addr_i;
      entry_d.data  = (entry_q.data & ~wmask_s) | (wdata_i & wmask_s);
      entry_d.mask  = wbe_i;
    end else if (merge_i) begin
      entry_d.data  = (entry_q.data & ~wmask_s) | (wdata_i & wmask_s);
      entry_d.mask  = entry_q.mask | wbe_i;
    end else begin
      entry_d = entry_q;
    end
  end

  // Entry register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign match_o = entry_q.valid && (entry_q.addr == addr_i);
  assign addr_o  = entry_q.addr;
  assign data_o  = entry_q.data;
  assign mask_o  = entry_q.mask;

endmodule

// File: rtl/ram1p_wbuf.sv
// Coalescing write buffer in front of a single-port byte-enable SRAM, with
// per-byte forwarding of buffered data into read responses.
module ram1p_wbuf
  import ram1p_wbuf_pkg::*;
#(
  parameter int DEPTH        = DEPTH_DEF,
  parameter int WIDTH        = WIDTH_DEF,
  parameter int NENTRIES     = NENTRIES_DEF,
  parameter int STARVE_LIMIT = STARVE_DEF
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     ReqValid,
  output logic                     ReqReady,
  input  logic                     ReqWrite,
  input  logic [$clog2(DEPTH)-1:0] ReqAddr,
  input  logic [WIDTH-1:0]         ReqData,
  input  logic [(WIDTH-1)/8:0]     ReqBwe,
  output logic                     RspValid,
  output logic [WIDTH-1:0]         RspData,
  output logic                     ce,
  output logic                     we,
  output logic [$clog2(DEPTH)-1:0] addr,
  output logic [WIDTH-1:0]         din,
  output logic [(WIDTH-1)/8:0]     bwe,
  input  logic [WIDTH-1:0]         dout
);

  localparam int AW = $clog2(DEPTH);
  localparam int NB = lanes_of(WIDTH);
  localparam int PW = (NENTRIES > 1) ? $clog2(NENTRIES) : 1;
  localparam int CW = $clog2(NENTRIES + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0]    count_q, count_d;
  logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [SW-1:0]    starve_q, starve_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [NB-1:0]    fwd_mask_q, fwd_mask_d;
  logic [WIDTH-1:0] fwd_data_q, fwd_data_d;

  logic                accept_s, wr_acc_s, rd_acc_s, alloc_s, drain_s, hit_s;
  logic [NB-1:0]       hit_mask_s;
  logic [WIDTH-1:0]    hit_data_s, fwd_bits_s;
  logic [NENTRIES-1:0] ent_match_s;
  logic [AW-1:0]       ent_addr_s [NENTRIES];
  logic [WIDTH-1:0]    ent_data_s [NENTRIES];
  logic [NB-1:0]       ent_mask_s [NENTRIES];

  // Advance a ring pointer, wrapping at the last entry.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(NENTRIES - 1)) ? '0 : p + PW'(1);
  endfunction

  // Expand a lane enable vector into a per-bit mask.
  function automatic logic [WIDTH-1:0] lane_bits(input logic [NB-1:0] be);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int b = 0; b < WIDTH; b++) begin
      r[b] = be[b / 8];
    end
    return r;
  endfunction

  // Handshake: ready ignores ReqValid; a drain takes any cycle without an accept.
  assign ReqReady = resetn && (count_q != CW'(NENTRIES)) && (starve_q != SW'(STARVE_LIMIT));
  assign accept_s = ReqValid && ReqReady;
  assign wr_acc_s = accept_s && ReqWrite;
  assign rd_acc_s = accept_s && !ReqWrite;
  assign drain_s  = resetn && (count_q != '0) && !accept_s;
  assign alloc_s  = wr_acc_s && !hit_s;

  for (genvar i = 0; i < NENTRIES; i++) begin : g_ent
    ram1p_wbuf_wbufentry #(.AW(AW), .WIDTH(WIDTH), .NB(NB)) u_ent (
      .clk     (clk),
      .resetn  (resetn),
      .alloc_i (alloc_s && (tail_q == PW'(i))),
      .merge_i (wr_acc_s && ent_match_s[i]),
      .pop_i   (drain_s && (head_q == PW'(i))),
      .addr_i  (ReqAddr),
      .wdata_i (ReqData),
      .wbe_i   (ReqBwe),
      .match_o (ent_match_s[i]),
      .addr_o  (ent_addr_s[i]),
      .data_o  (ent_data_s[i]),
      .mask_o  (ent_mask_s[i])
    );
  end

  // Select the (unique) entry matching the request address.
  always_comb begin
    hit_s      = 1'b0;
    hit_mask_s = '0;
    hit_data_s = '0;
    for (int i = 0; i < NENTRIES; i++) begin
      if (ent_match_s[i]) begin
        hit_s      = 1'b1;
        hit_mask_s = ent_mask_s[i];
        hit_data_s = ent_data_s[i];
      end else begin
        hit_s      = hit_s;
      end
    end
  end

  // RAM port: read on a read accept, write the head entry on a drain.
  assign ce   = rd_acc_s || drain_s;
  assign we   = drain_s;
  assign addr = drain_s ? ent_addr_s[head_q] : ReqAddr;
  assign din  = drain_s ? ent_data_s[head_q] : '0;
  assign bwe  = drain_s ? ent_mask_s[head_q] : '0;

  // Read response merges the forward snapshot over the RAM data lane by lane.
  assign fwd_bits_s = lane_bits(fwd_mask_q);
  assign RspValid   = rsp_valid_q;
  assign RspData    = (fwd_data_q & fwd_bits_s) | (dout & ~fwd_bits_s);

  // Next-state for occupancy, pointers, starvation counter and forward snapshot.
  always_comb begin
    count_d     = count_q;
    head_d      = drain_s ? ptr_inc(head_q) : head_q;
    tail_d      = alloc_s ? ptr_inc(tail_q) : tail_q;
    rsp_valid_d = rd_acc_s;
    fwd_mask_d  = rd_acc_s ? hit_mask_s : fwd_mask_q;
    fwd_data_d  = rd_acc_s ? hit_data_s : fwd_data_q;
    case ({alloc_s, drain_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (drain_s || (count_q == '0)) begin
      starve_d = '0;
    end else if (accept_s) begin
      starve_d = starve_q + SW'(1);
    end else begin
      starve_d = starve_q;
    end
  end

  // Control and snapshot registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      count_q     <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      starve_q    <= '0;
      rsp_valid_q <= 1'b0;
      fwd_mask_q  <= '0;
      fwd_data_q  <= '0;
    end else begin
      count_q     <= count_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      starve_q    <= starve_d;
      rsp_valid_q <= rsp_valid_d;
      fwd_mask_q  <= fwd_mask_d;
      fwd_data_q  <= fwd_data_d;
    end
  end

  ram1p_wbuf_chk u_chk (
    .clk      (clk),
    .resetn   (resetn),
    .accept_i (accept_s),
    .drain_i  (drain_s)
  );

endmodule

// File: tb/tb_ram1p_wbuf.sv
// Directed bench for ram1p_wbuf with a behavioural byte-enable RAM model.
module tb_ram1p_wbuf;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ReqValid, ReqReady, ReqWrite;
  logic [5:0]  ReqAddr;
  logic [63:0] ReqData;
  logic [7:0]  ReqBwe;
  logic        RspValid;
  logic [63:0] RspData;
  logic        ce, we;
  logic [5:0]  addr;
  logic [63:0] din;
  logic [7:0]  bwe;
  logic [63:0] dout = 64'h0;
  logic [63:0] mem [64] = '{default: 64'h0};

  int n_run  = 0;
  int n_fail = 0;

  ram1p_wbuf dut (
    .clk(clk), .resetn(resetn), .ReqValid(ReqValid), .ReqReady(ReqReady),
    .ReqWrite(ReqWrite), .ReqAddr(ReqAddr), .ReqData(ReqData), .ReqBwe(ReqBwe),
    .RspValid(RspValid), .RspData(RspData), .ce(ce), .we(we), .addr(addr),
    .din(din), .bwe(bwe), .dout(dout)
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM: byte-enable write, one-cycle read latency.
  always @(posedge clk) begin
    if (ce) begin
      if (we) begin
        for (int l = 0; l < 8; l++) begin
          if (bwe[l]) mem[addr][l*8 +: 8] <= din[l*8 +: 8];
        end
      end else begin
        dout <= mem[addr];
      end
    end
  end

  task automatic drv(input logic v, input logic w, input logic [5:0] a,
                     input logic [63:0] d, input logic [7:0] be);
    ReqValid = v; ReqWrite = w; ReqAddr = a; ReqData = d; ReqBwe = be;
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    drv(1'b1, 1'b0, 6'd7, 64'h0, 8'h00);
    for (int c = 0; c < 2; c++) begin
      nxt(); smp();
      n_run++; if (ce !== 1'b0) begin n_fail++; $display("FAIL reset_ce got=%0h exp=0", ce); end
      n_run++; if (RspValid !== 1'b0) begin n_fail++; $display("FAIL reset_rspvalid got=%0h exp=0", RspValid); end
    end
    nxt();
    resetn = 1'b1;
    drv(1'b0, 1'b0, 6'd0, 64'h0, 8'h00);
    smp();
    n_run++; if (ReqReady !== 1'b1) begin n_fail++; $display("FAIL release_ready got=%0h exp=1", ReqReady); end
    n_run++; if (ce !== 1'b0) begin n_fail++; $display("FAIL release_idle_ce got=%0h exp=0", ce); end
    nxt();
  endtask

  task automatic test_write_drain_read();
    drv(1'b1, 1'b1, 6'd5, 64'h1122334455667788, 8'hFF); smp();
    n_run++; if (ce !== 1'b0) begin n_fail++; $display("FAIL wdr_wr_ce got=%0h exp=0", ce); end
    nxt();
    drv(1'b0, 1'b0, 6'd0, 64'h0, 8'h00); smp();
    n_run++; if ({ce, we} !== 2'b11) begin n_fail++; $display("FAIL wdr_drain_cewe got=%0h exp=3", {ce, we}); end
    n_run++; if (addr !== 6'd5) begin n_fail++; $display("FAIL wdr_drain_addr got=%0h exp=5", addr); end
    n_run++; if (bwe !== 8'hFF) begin n_fail++; $display("FAIL wdr_drain_bwe got=%0h exp=ff", bwe); end
    n_run++; if (din !== 64'h1122334455667788) begin n_fail++; $display("FAIL wdr_drain_din got=%0h exp=1122334455667788", din); end
    nxt();
    drv(1'b1, 1'b0, 6'd5, 64'h0, 8'h00); smp();
    n_run++; if ({ce, we, addr} !== {2'b10, 6'd5}) begin n_fail++; $display("FAIL wdr_rd_port got=%0h exp=%0h", {ce, we, addr}, {2'b10, 6'd5}); end
    nxt();
    drv(1'b0, 1'b0, 6'd0, 64'h0, 8'h00); smp();
    n_run++; if (RspValid !== 1'b1) begin n_fail++; $display("FAIL wdr_rspvalid got=%0h exp=1", RspValid); end
    n_run++; if (RspData !== 64'h1122334455667788) begin n_fail++; $display("FAIL wdr_rspdata got=%0h exp=1122334455667788", RspData); end
    n_run++; if (ce !== 1'b0) begin n_fail++; $display("FAIL wdr_idle_ce got=%0h exp=0", ce); end
    nxt(); smp();
    n_run++; if (RspValid !== 1'b0) begin n_fail++; $display("FAIL wdr_rspvalid_pulse got=%0h exp=0", RspValid); end
  endtask

  task automatic test_forward();
    drv(1'b1, 1'b1, 6'd3, 64'hAAAAAAAABBBBBBBB, 8'h0F); nxt();
    drv(1'b1, 1'b0, 6'd3, 64'h0, 8'h00); smp();
    n_run++; if ({ce, we} !== 2'b10) begin n_fail++; $display("FAIL fwd_rd_cewe got=%0h exp=2", {ce, we}); end
    nxt();
    drv(1'b0, 1'b0, 6'd0, 64'h0, 8'h00); smp();
    n_run++; if (RspData !== 64'h00000000BBBBBBBB) begin n_fail++; $display("FAIL fwd_rspdata got=%0h exp=00000000bbbbbbbb", RspData); end
    n_run++; if ({ce, we, addr, bwe} !== {2'b11, 6'd3, 8'h0F}) begin n_fail++; $display("FAIL fwd_drain got=%0h exp=%0h", {ce, we, addr, bwe}, {2'b11, 6'd3, 8'h0F}); end
    nxt(); smp();
    n_run++; if (ce !== 1'b0) begin n_fail++; $display("FAIL fwd_empty_ce got=%0h exp=0", ce); end
    nxt();
  endtask

  task automatic test_merge();
    drv(1'b1, 1'b1, 6'd9, 64'h11, 8'h01); nxt();
    drv(1'b1, 1'b1, 6'd9, 64'h2200, 8'h02); smp();
    n_run++; if ({ReqReady, ce} !== 2'b10) begin n_fail++; $display("FAIL merge_accept got=%0h exp=2", {ReqReady, ce}); end
    nxt();
    drv(1'b0, 1'b0, 6'd0, 64'h0, 8'h00); smp();
    n_run++; if ({ce, we, addr, bwe} !== {2'b11, 6'd9, 8'h03}) begin n_fail++; $display("FAIL merge_drain got=%0h exp=%0h", {ce, we, addr, bwe}, {2'b11, 6'd9, 8'h03}); end
    n_run++; if (din[15:0] !== 16'h2211) begin n_fail++; $display("FAIL merge_din got=%0h exp=2211", din[15:0]); end
    nxt(); smp();
    n_run++; if (ce !== 1'b0) begin n_fail++; $display("FAIL merge_single_entry got=%0h exp=0", ce); end
    nxt();
  endtask

  task automatic test_full();
    logic [5:0] exp_a [4];
    exp_a[0] = 6'd1; exp_a[1] = 6'd2; exp_a[2] = 6'd3; exp_a[3] = 6'd32;
    for (int i = 0; i < 4; i++) begin
      drv(1'b1, 1'b1, 6'(i), 64'h100 + 64'(i), 8'hFF); nxt();
    end
    drv(1'b1, 1'b1, 6'd32, 64'hDEAD, 8'hFF); smp();
    n_run++; if (ReqReady !== 1'b0) begin n_fail++; $display("FAIL full_ready got=%0h exp=0", ReqReady); end
    n_run++; if ({ce, we, addr} !== {2'b11, 6'd0}) begin n_fail++; $display("FAIL full_drain0 got=%0h exp=%0h", {ce, we, addr}, {2'b11, 6'd0}); end
    nxt(); smp();
    n_run++; if ({ReqReady, ce} !== 2'b10) begin n_fail++; $display("FAIL full_accept5 got=%0h exp=2", {ReqReady, ce}); end
    nxt();
    drv(1'b0, 1'b0, 6'd0, 64'h0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      smp();
      n_run++; if ({ce, we, addr} !== {2'b11, exp_a[i]}) begin n_fail++; $display("FAIL full_order%0d got=%0h exp=%0h", i, {ce, we, addr}, {2'b11, exp_a[i]}); end
      if (i == 3) begin
        n_run++; if (din !== 64'hDEAD) begin n_fail++; $display("FAIL full_din5 got=%0h exp=dead", din); end
      end
      nxt();
    end
    smp();
    n_run++; if (ce !== 1'b0) begin n_fail++; $display("FAIL full_empty got=%0h exp=0", ce); end
    nxt();
  endtask

  task automatic test_starve();
    drv(1'b1, 1'b1, 6'd1, 64'h55, 8'h01); nxt();
    for (int i = 0; i < 8; i++) begin
      drv(1'b1, 1'b0, 6'd10 + 6'(i), 64'h0, 8'h00); smp();
      n_run++; if ({ReqReady, ce, we} !== 3'b110) begin n_fail++; $display("FAIL starve_rd%0d got=%0h exp=6", i, {ReqReady, ce, we}); end
      nxt();
    end
    drv(1'b1, 1'b0, 6'd20, 64'h0, 8'h00); smp();
    n_run++; if (ReqReady !== 1'b0) begin n_fail++; $display("FAIL starve_ready got=%0h exp=0", ReqReady); end
    n_run++; if ({ce, we, addr, bwe} !== {2'b11, 6'd1, 8'h01}) begin n_fail++; $display("FAIL starve_drain got=%0h exp=%0h", {ce, we, addr, bwe}, {2'b11, 6'd1, 8'h01}); end
    nxt(); smp();
    n_run++; if ({ReqReady, ce, we, addr} !== {3'b110, 6'd20}) begin n_fail++; $display("FAIL starve_resume got=%0h exp=%0h", {ReqReady, ce, we, addr}, {3'b110, 6'd20}); end
    nxt();
    drv(1'b0, 1'b0, 6'd0, 64'h0, 8'h00); smp();
    n_run++; if ({RspValid, ce} !== 2'b10) begin n_fail++; $display("FAIL starve_tail got=%0h exp=2", {RspValid, ce}); end
    nxt();
  endtask

  task automatic test_back_to_back();
    drv(1'b1, 1'b0, 6'd5, 64'h0, 8'h00); nxt();
    drv(1'b1, 1'b1, 6'd5, 64'hFFFFFFFFFFFFFFFF, 8'hFF); smp();
    n_run++; if (RspData !== 64'h1122334455667788) begin n_fail++; $display("FAIL b2b_preimage got=%0h exp=1122334455667788", RspData); end
    nxt();
    drv(1'b0, 1'b0, 6'd0, 64'h0, 8'h00); smp();
    n_run++; if ({ce, we, addr, din} !== {2'b11, 6'd5, 64'hFFFFFFFFFFFFFFFF}) begin n_fail++; $display("FAIL b2b_drain got=%0h exp=%0h", {ce, we, addr, din}, {2'b11, 6'd5, 64'hFFFFFFFFFFFFFFFF}); end
    nxt();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write_drain_read();
    test_forward();
    test_merge();
    test_full();
    test_starve();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/ram1p_wbuf.md
Name: ram1p_wbuf

Overview:
- Write-buffer front end that sits directly upstream of the single-port byte-enable cache SRAM (ram1p1rwbe).
- Accepts a stream of read/write requests over a valid/ready port.
- Holds writes in a small coalescing buffer and drains them into the RAM when the port is idle.
- Serves reads from the RAM with per-byte forwarding of buffered data, so reads never see stale bytes.

Parameters:
- DEPTH, 64, RAM words; must match the downstream RAM.
- WIDTH, 64, bits per word; byte lanes NB = (WIDTH-1)/8+1; the top lane is partial when WIDTH%8 != 0.
- NENTRIES, 4, write-buffer entries (>=2).
- STARVE_LIMIT, 8, consecutive accepted requests with a non-empty buffer before a drain is forced.

Ports:
- clk  in  1  clock.
- resetn  in  1  reset.
- ReqValid  in  1  request valid.
- ReqReady  out  1  request ready.
- ReqWrite  in  1  1=write, 0=read.
- ReqAddr  in  $clog2(DEPTH)  word address.
- ReqData  in  WIDTH  write data.
- ReqBwe  in  NB  byte write enables.
- RspValid  out  1  read data valid, one cycle, no backpressure.
- RspData  out  WIDTH  read data.
- ce  out  1  RAM chip enable.
- we  out  1  RAM write enable.
- addr  out  $clog2(DEPTH)  RAM address.
- din  out  WIDTH  RAM write data.
- bwe  out  NB  RAM byte enables.
- dout  in  WIDTH  RAM read data; valid the cycle after the ce read.

Interface: one clock (clk); reset (resetn) is synchronous and active-low.

Behaviour:
- Reset (resetn=0 at posedge):
  - Buffer count=0, all entries invalid, starve counter=0, RspValid=0.
  - Buffered writes are discarded; any in-flight read response is dropped.
  - ce/we are combinational and are 0 while count=0 and no request is presented.
- Accept condition: Accept = ReqValid & ReqReady.
  - ReqReady = ~Full & ~(StarveCnt==STARVE_LIMIT).
  - ReqReady does not depend on ReqValid.
- Write accept:
  - If an entry's address equals ReqAddr, merge into it: lanes with ReqBwe set overwrite data and OR into the entry mask.
  - Otherwise allocate a new tail entry with {addr, data, mask=ReqBwe}.
  - Addresses in the buffer are always unique. No RAM access occurs in that cycle.
- Read accept (cycle t):
  - ce=1, we=0, addr=ReqAddr.
  - Forward snapshot registered at t: FwdMask = mask of the matching entry (0 if none), FwdData = its data.
  - At t+1: RspValid=1, RspData lane i = FwdMask[i] ? FwdData lane : dout lane. Latency is exactly 1.
- Drain:
  - Occurs in any cycle with count>0 and no accept.
  - ce=1, we=1, addr/din/bwe = head entry.
  - Head pops at the clock edge. Entries leave in FIFO order.
- Idle: count=0 and no accept -> ce=0, we=0.
- Starve counter:
  - Increments on each accept while count>0.
  - Clears on any drain or when count=0.
  - At STARVE_LIMIT, ReqReady=0 for one cycle and the drain occurs.
- Full (count==NENTRIES):
  - ReqReady=0, including writes that would merge.
  - Drain occurs; ReqReady=1 the next cycle.
- Read then write to the same address in consecutive cycles: the read response reflects pre-write state.
- Write then read in consecutive cycles: the read forwards the new bytes.
- Count arithmetic: $clog2(NENTRIES+1) bits. Head/tail pointers wrap modulo NENTRIES.
- Assertion: accept and drain are never in the same cycle.

Decomposition:
- No new package types; the entry struct is local because it is parametric on WIDTH/NB.
- Constants NB and the pointer width are localparams.
- Sub-module wbufentry: one entry, holding valid/addr/data/mask registers, address compare, and byte merge.
  - Instantiated NENTRIES times.
  - Outputs match and mask/data for forwarding.
- Head/tail/count and the forward snapshot use existing flopenr-style primitives.

Test Plan:
- Reset: resetn=0 for 2 cycles with ReqValid=1 -> ce=0, RspValid=0; after release ReqReady=1, count=0.
- Write/drain/read:
  - W addr5 data 0x1122334455667788 bwe 0xFF at t0, idle at t1 -> t1 ce=1 we=1 addr=5 bwe=0xFF.
  - R addr5 at t2 -> t3 RspValid=1, RspData=0x1122334455667788.
- Forward:
  - After RAM[3]=0, W addr3 data 0xAAAAAAAABBBBBBBB bwe 0x0F at t0, R addr3 at t1.
  - -> t2 RspData=0x00000000BBBBBBBB; t2 drain addr3 bwe 0x0F.
- Merge:
  - W addr9 bwe 0x01 data 0x11 at t0, W addr9 bwe 0x02 data 0x2200 at t1 -> count stays 1.
  - t2 drain addr9 bwe 0x03 din[15:0]=0x2211.
- Full:
  - W addr0..3 on t0..t3 with a 5th W held valid -> t4 ReqReady=0, drain addr0.
  - t5 5th write accepted; drains follow in order addr1, 2, 3, 5th.
- Starvation: W addr1 at t0, then continuous reads -> after 8 accepted reads ReqReady=0 for one cycle, drain addr1 that cycle, then reads resume.
